conway_board_reader: RTL and testbench
======================================

CONWAY_BOARD_READER -- requirements
Module: conway_board_reader

Interface
REQ-001 Parameter ROWS, default 8: board height in cells.
REQ-002 Parameter COLS, default 8: board width in cells.
REQ-003 clk  input  1: single clock; all state changes on rising edge.
REQ-004 rst  input  1: reset, asynchronous, active-low.
REQ-005 ena  input  1: generation-complete strobe from the cell array; one-cycle pulse.
REQ-006 cells  input  ROWS*COLS: live state of every cell (state_q of each cell); bit r*COLS+c = row r, column c.
REQ-007 row_data  output  COLS: snapshot bits of the current row; bit c = column c.
REQ-008 row_idx  output  $clog2(ROWS): index of the row on row_data.
REQ-009 row_valid  output  1: row_data/row_idx valid.
REQ-010 row_ready  input  1: downstream accepts the row when row_valid&row_ready.
REQ-011 frame_start  output  1: high with row_valid while row_idx==0.
REQ-012 frame_done  output  1: one-cycle pulse in the cycle after the last row is accepted.
REQ-013 overrun  output  1: sticky; set when ena arrives while a frame is in progress.

Function
REQ-014 FSM states IDLE, SEND, DONE; encoding from the shared enum.
REQ-015 IDLE: on ena==1, capture cells into an internal snapshot register, set row_idx=0, go to SEND next cycle; row_valid rises one cycle after ena (latency 1).
REQ-016 SEND: row_valid=1, row_data=snapshot row row_idx; row_data/row_idx held stable until handshake.
REQ-017 SEND handshake with row_idx<ROWS-1: increment row_idx, stay in SEND; no idle cycle between rows.
REQ-018 SEND handshake with row_idx==ROWS-1: go to DONE; row_valid=0 in DONE.
REQ-019 DONE: frame_done=1 for exactly one cycle, then IDLE.
REQ-020 ena in SEND or DONE: snapshot unchanged, frame not restarted, overrun set to 1.
REQ-021 ena in IDLE coinciding with nothing pending: no overrun; the ena in the same cycle DONE->IDLE transitions counts as in DONE (overrun, dropped).
REQ-022 row_ready while row_valid==0: ignored.
REQ-023 cells changing after capture: no effect on the frame in progress.
REQ-024 overrun cleared only by reset.

Reset
REQ-025 rst low: state IDLE, row_idx=0, row_valid=0, frame_start=0, frame_done=0, overrun=0, snapshot all 0, popcount 0 when present; takes effect immediately, independent of clk.
REQ-026 Reset mid-frame: frame abandoned, no frame_done issued; first ena after rst release starts a fresh frame.

Configuration
REQ-027 Macro CONWAY_READER_POPCOUNT_EN defined: extra output live_count, width $clog2(ROWS*COLS+1), equals number of 1s in the snapshot, valid from first row_valid cycle, held until next capture.
REQ-028 Macro undefined: no live_count port, no popcount logic; all other behaviour identical.

Structure
REQ-029 Shared package conway_pkg holds default ROWS/COLS constants and the reader state enum typedef.
REQ-030 Popcount implemented in sub-module row_popcount (COLS-bit count per row, accumulated across rows or summed combinationally over snapshot), instantiated only under CONWAY_READER_POPCOUNT_EN.

Verification
REQ-031 ROWS=COLS=8, cells=64'h8142_2418_1824_4281, ena pulse, row_ready held 1 -> rows 0..7 emitted on 8 consecutive cycles starting 1 cycle after ena, row0=8'h81, row7=8'h81, frame_start only on row 0, frame_done one cycle after row 7 accepted.
REQ-032 Same stimulus, row_ready toggled 1-0-0-1 pattern -> row_data/row_idx stable during stalls, exactly 8 handshakes, no row repeated or skipped.
REQ-033 ena pulsed again during row 3 with cells changed to all 1s -> remaining rows still from original snapshot, overrun=1 and stays 1 through next frame.
REQ-034 rst asserted asynchronously mid-row 5 -> row_valid=0 and overrun=0 before next clk edge, no frame_done; next ena yields a complete frame from row 0.
REQ-035 With CONWAY_READER_POPCOUNT_EN, cells=all 1s -> live_count=64; cells=0 -> live_count=0; glider (5 live) -> live_count=5.

Source files
------------

// File: rtl/conway_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// conway_pkg : board size defaults and reader FSM encoding shared by the reader
// Rev 1.0
// ---------------------------------------------------------------------------
package conway_pkg;

  localparam int C_ROWS_DEFAULT = 8;
  localparam int C_COLS_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } reader_state_e;

  // Keeps index ports at least one bit wide on single-row boards.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/row_popcount.sv
`default_nettype none
// ---------------------------------------------------------------------------
// row_popcount : number of live cells in one board row (CONWAY_READER_POPCOUNT_EN)
// Rev 1.0
// ---------------------------------------------------------------------------
`ifdef CONWAY_READER_POPCOUNT_EN
module row_popcount
  import conway_pkg::*;
#(
  parameter int COLS  = C_COLS_DEFAULT,
  parameter int CNT_W = $clog2(COLS + 1)
) (
  input  logic [COLS-1:0]  row_i,
  output logic [CNT_W-1:0] count_o
);

  always_comb begin
    count_o = '0;
    for (int c = 0; c < COLS; c++) begin
      count_o = count_o + CNT_W'(row_i[c]);
    end
  end

endmodule
`endif
`default_nettype wire

// File: rtl/conway_board_reader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// conway_board_reader : snapshots the cell array on ena, streams it row by row
// Option CONWAY_READER_POPCOUNT_EN adds live_count. Rev 1.0
// ---------------------------------------------------------------------------
module conway_board_reader
  import conway_pkg::*;
#(
  parameter int ROWS = C_ROWS_DEFAULT,
  parameter int COLS = C_COLS_DEFAULT,
  localparam int IDX_W = idx_width(ROWS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic [ROWS*COLS-1:0] cells,
  output logic [COLS-1:0]      row_data,
  output logic [IDX_W-1:0]     row_idx,
  output logic                 row_valid,
  input  logic                 row_ready,
  output logic                 frame_start,
  output logic                 frame_done,
  output logic                 overrun
`ifdef CONWAY_READER_POPCOUNT_EN
  ,
  output logic [$clog2(ROWS*COLS+1)-1:0] live_count
`endif
);

  reader_state_e        state_q, state_d;
  logic [ROWS*COLS-1:0] snap_q, snap_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 ovr_q, ovr_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      snap_q  <= '0;
      idx_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      idx_q   <= idx_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    snap_d     = snap_q;
    idx_d      = idx_q;
    ovr_d      = ovr_q;
    row_valid  = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ena) begin
          snap_d  = cells;
          idx_d   = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        row_valid = 1'b1;
        if (ena) ovr_d = 1'b1;
        if (row_ready) begin
          if (idx_q == IDX_W'(ROWS - 1)) state_d = ST_DONE;
          else                           idx_d   = idx_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        // A strobe landing on the way back to idle still belongs to this frame.
        frame_done = 1'b1;
        idx_d      = '0;
        state_d    = ST_IDLE;
        if (ena) ovr_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    row_data = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (idx_q == IDX_W'(r)) row_data = snap_q[r*COLS +: COLS];
    end
  end

  assign row_idx     = idx_q;
  assign frame_start = row_valid && (idx_q == '0);
  assign overrun     = ovr_q;

`ifdef CONWAY_READER_POPCOUNT_EN
  localparam int CNT_W     = $clog2(ROWS*COLS + 1);
  localparam int ROW_CNT_W = $clog2(COLS + 1);

  logic [ROW_CNT_W-1:0] row_cnt [ROWS];

  for (genvar r = 0; r < ROWS; r++) begin : g_row_pop
    row_popcount #(
      .COLS  (COLS),
      .CNT_W (ROW_CNT_W)
    ) u_row_popcount (
      .row_i   (snap_q[r*COLS +: COLS]),
      .count_o (row_cnt[r])
    );
  end

  always_comb begin
    live_count = '0;
    for (int r = 0; r < ROWS; r++) begin
      live_count = live_count + CNT_W'(row_cnt[r]);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_conway_board_reader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_conway_board_reader : directed vectors, corner sequences and random traffic
// compared against a row-queue model of the reader. Rev 1.0
// ---------------------------------------------------------------------------
module tb_conway_board_reader;
  import conway_pkg::*;

  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam logic [63:0] C_PAT    = 64'h8142_2418_1824_4281;
  localparam logic [63:0] C_GLIDER = 64'h0000_0000_0007_0402;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b0;
  logic        row_ready = 1'b0;
  logic [63:0] cells = '0;
  logic [7:0]  row_data;
  logic [2:0]  row_idx;
  logic        row_valid, frame_start, frame_done, overrun;
`ifdef CONWAY_READER_POPCOUNT_EN
  logic [6:0]  live_count;
`endif

  always #5 clk = ~clk;

  conway_board_reader #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .cells       (cells),
    .row_data    (row_data),
    .row_idx     (row_idx),
    .row_valid   (row_valid),
    .row_ready   (row_ready),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .overrun     (overrun)
`ifdef CONWAY_READER_POPCOUNT_EN
    ,
    .live_count  (live_count)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a pending frame is just the list of rows still to be delivered.
  typedef struct packed {
    logic [2:0] idx;
    logic [7:0] data;
  } row_t;

  row_t m_q[$];
  bit   m_done;
  bit   m_ov;
  int   m_live;

  function automatic void model_reset();
    m_q.delete();
    m_done = 1'b0;
    m_ov   = 1'b0;
    m_live = 0;
  endfunction

  function automatic void model_step();
    row_t e;
    if (!rst) begin
      model_reset();
      return;
    end
    if (m_done) begin
      m_done = 1'b0;
      if (ena) m_ov = 1'b1;
    end else if (m_q.size() > 0) begin
      if (ena) m_ov = 1'b1;
      if (row_ready) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) m_done = 1'b1;
      end
    end else if (ena) begin
      m_live = 0;
      for (int r = 0; r < ROWS; r++) begin
        e.idx  = 3'(r);
        e.data = cells[r*COLS +: COLS];
        m_q.push_back(e);
      end
      for (int b = 0; b < ROWS*COLS; b++) m_live += int'(cells[b]);
    end
  endfunction

  task automatic check_model(input string tag);
    check({tag, ".valid"}, 64'(row_valid), 64'(m_q.size() > 0));
    check({tag, ".done"},  64'(frame_done), 64'(m_done));
    check({tag, ".ovr"},   64'(overrun), 64'(m_ov));
    if (m_q.size() > 0) begin
      check({tag, ".idx"},  64'(row_idx), 64'(m_q[0].idx));
      check({tag, ".data"}, 64'(row_data), 64'(m_q[0].data));
      check({tag, ".fs"},   64'(frame_start), 64'(m_q[0].idx == 3'd0));
    end else begin
      check({tag, ".fs"}, 64'(frame_start), 64'd0);
    end
`ifdef CONWAY_READER_POPCOUNT_EN
    check({tag, ".live"}, 64'(live_count), 64'(m_live));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    ena = 1'b0;
    row_ready = 1'b0;
    #1;
    tick();
    rst = 1'b1;
  endtask

  typedef struct {
    logic        ena;
    logic        rdy;
    logic [63:0] cells;
    logic        exp_v;
    logic [2:0]  exp_idx;
    logic [7:0]  exp_data;
    logic        exp_fs;
    logic        exp_fd;
    logic        exp_ov;
  } vec_t;

  vec_t vt[12];

  function automatic vec_t mk(input logic e, input logic r, input logic [63:0] c, input logic v,
                              input logic [2:0] i, input logic [7:0] d, input logic fs,
                              input logic fd, input logic ov);
    vec_t x;
    x.ena = e; x.rdy = r; x.cells = c; x.exp_v = v; x.exp_idx = i;
    x.exp_data = d; x.exp_fs = fs; x.exp_fd = fd; x.exp_ov = ov;
    return x;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] ref_pat;
    int          hs;
    ref_pat = C_PAT;

    vt[0]  = mk(1'b1, 1'b1, C_PAT, 1'b1, 3'd0, 8'h81, 1'b1, 1'b0, 1'b0);
    vt[1]  = mk(1'b0, 1'b1, C_PAT, 1'b1, 3'd1, 8'h42, 1'b0, 1'b0, 1'b0);
    vt[2]  = mk(1'b0, 1'b1, C_PAT, 1'b1, 3'd2, 8'h24, 1'b0, 1'b0, 1'b0);
    vt[3]  = mk(1'b0, 1'b1, C_PAT, 1'b1, 3'd3, 8'h18, 1'b0, 1'b0, 1'b0);
    vt[4]  = mk(1'b0, 1'b1, C_PAT, 1'b1, 3'd4, 8'h18, 1'b0, 1'b0, 1'b0);
    vt[5]  = mk(1'b0, 1'b1, C_PAT, 1'b1, 3'd5, 8'h24, 1'b0, 1'b0, 1'b0);
    vt[6]  = mk(1'b0, 1'b1, C_PAT, 1'b1, 3'd6, 8'h42, 1'b0, 1'b0, 1'b0);
    vt[7]  = mk(1'b0, 1'b1, C_PAT, 1'b1, 3'd7, 8'h81, 1'b0, 1'b0, 1'b0);
    vt[8]  = mk(1'b0, 1'b1, C_PAT, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0);
    vt[9]  = mk(1'b1, 1'b1, 64'hF0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1);
    vt[10] = mk(1'b1, 1'b0, 64'hF0, 1'b1, 3'd0, 8'hF0, 1'b1, 1'b0, 1'b1);
    vt[11] = mk(1'b0, 1'b0, 64'hF0, 1'b1, 3'd0, 8'hF0, 1'b1, 1'b0, 1'b1);

    // Reset state
    model_reset();
    #1 rst = 1'b0;
    #2;
    check("rst.valid", 64'(row_valid), 64'd0);
    check("rst.idx",   64'(row_idx), 64'd0);
    check("rst.fs",    64'(frame_start), 64'd0);
    check("rst.fd",    64'(frame_done), 64'd0);
    check("rst.ovr",   64'(overrun), 64'd0);
`ifdef CONWAY_READER_POPCOUNT_EN
    check("rst.live",  64'(live_count), 64'd0);
`endif
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Directed table: full frame with ready held, ena in DONE, restart
    for (int k = 0; k < 12; k++) begin
      ena = vt[k].ena;
      row_ready = vt[k].rdy;
      cells = vt[k].cells;
      tick();
      check($sformatf("vec%0d.valid", k), 64'(row_valid), 64'(vt[k].exp_v));
      check($sformatf("vec%0d.fs", k),    64'(frame_start), 64'(vt[k].exp_fs));
      check($sformatf("vec%0d.fd", k),    64'(frame_done), 64'(vt[k].exp_fd));
      check($sformatf("vec%0d.ovr", k),   64'(overrun), 64'(vt[k].exp_ov));
      if (vt[k].exp_v) begin
        check($sformatf("vec%0d.idx", k),  64'(row_idx), 64'(vt[k].exp_idx));
        check($sformatf("vec%0d.data", k), 64'(row_data), 64'(vt[k].exp_data));
      end
    end
    ena = 1'b0;

    // Stalls with ready pattern 1-0-0-1
    do_reset();
    cells = C_PAT;
    ena = 1'b1;
    tick();
    ena = 1'b0;
    check_model("stall");
    hs = 0;
    for (int cyc = 0; cyc < 40 && !frame_done; cyc++) begin
      logic [2:0] p_idx;
      logic [7:0] p_data;
      logic       p_v;
      row_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      p_idx  = row_idx;
      p_data = row_data;
      p_v    = row_valid;
      if (p_v && row_ready) begin
        check("stall.hs_idx",  64'(p_idx), 64'(hs));
        check("stall.hs_data", 64'(p_data), 64'(ref_pat[hs*8 +: 8]));
        hs++;
      end
      tick();
      if (p_v && !row_ready) begin
        check("stall.idx_hold",  64'(row_idx), 64'(p_idx));
        check("stall.data_hold", 64'(row_data), 64'(p_data));
      end
      check_model("stall");
    end
    check("stall.handshakes", 64'(hs), 64'd8);
    check("stall.frame_done", 64'(frame_done), 64'd1);

    // ena during row 3 with new cells: frame continues from old snapshot
    do_reset();
    cells = C_PAT;
    ena = 1'b1;
    row_ready = 1'b1;
    tick();
    ena = 1'b0;
    for (int g = 0; g < 20 && !(row_valid && row_idx == 3'd3); g++) tick();
    check("ovr.reach_row3", 64'(row_idx), 64'd3);
    ena = 1'b1;
    cells = '1;
    tick();
    ena = 1'b0;
    check_model("ovr");
    for (int g = 0; g < 20 && row_valid; g++) begin
      check("ovr.old_row", 64'(row_data), 64'(ref_pat[row_idx*8 +: 8]));
      check("ovr.sticky",  64'(overrun), 64'd1);
      tick();
      check_model("ovr");
    end
    check("ovr.done", 64'(frame_done), 64'd1);
    tick();
    cells = C_GLIDER;
    ena = 1'b1;
    tick();
    ena = 1'b0;
    check("ovr.next_row0", 64'(row_data), 64'h02);
    for (int g = 0; g < 10; g++) begin
      check("ovr.next_sticky", 64'(overrun), 64'd1);
      tick();
      check_model("ovr2");
    end

    // Asynchronous reset in the middle of row 5
    do_reset();
    cells = C_PAT;
    ena = 1'b1;
    row_ready = 1'b1;
    tick();
    tick();
    ena = 1'b0;
    for (int g = 0; g < 20 && !(row_valid && row_idx == 3'd5); g++) tick();
    check("arst.reach_row5", 64'(row_idx), 64'd5);
    check("arst.ovr_pre",    64'(overrun), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("arst.valid", 64'(row_valid), 64'd0);
    check("arst.ovr",   64'(overrun), 64'd0);
    check("arst.fd",    64'(frame_done), 64'd0);
    check("arst.idx",   64'(row_idx), 64'd0);
    tick();
    check("arst.fd_hold", 64'(frame_done), 64'd0);
    rst = 1'b1;
    tick();
    check_model("arst_idle");
    cells = C_PAT;
    ena = 1'b1;
    tick();
    ena = 1'b0;
    check("arst.fresh_row0", 64'(row_data), 64'h81);
    for (int g = 0; g < 10; g++) begin
      check_model("arst_frame");
      tick();
    end
    check_model("arst_end");

`ifdef CONWAY_READER_POPCOUNT_EN
    // Popcount of the snapshot
    do_reset();
    cells = '1;
    ena = 1'b1;
    tick();
    ena = 1'b0;
    check("pop.all_ones", 64'(live_count), 64'd64);
    row_ready = 1'b1;
    for (int g = 0; g < 9; g++) tick();
    cells = '0;
    tick();
    check("pop.held", 64'(live_count), 64'd64);
    ena = 1'b1;
    tick();
    ena = 1'b0;
    check("pop.zero", 64'(live_count), 64'd0);
    for (int g = 0; g < 10; g++) tick();
    cells = C_GLIDER;
    ena = 1'b1;
    tick();
    ena = 1'b0;
    check("pop.glider", 64'(live_count), 64'd5);
    for (int g = 0; g < 10; g++) tick();
`endif

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ((c % 500) == 499) do_reset();
      ena = ($urandom_range(0, 9) == 0);
      row_ready = 1'($urandom_range(0, 1));
      cells = {$urandom, $urandom};
      tick();
      check_model("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
